// File: rtl/adder_pkg.sv
// adder_pkg -- shared constants for the pipelined adder.
//   DEFAULT_WIDTH  : default operand/sum width in bits
//   DEFAULT_STAGES : default number of pipeline stages
//   slice_width()  : bits handled by each stage (width must divide evenly)
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  function automatic int slice_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/adder_slice.sv
// adder_slice -- W-bit ripple-carry chain of full_adder cells.
//   a_i, b_i : slice operands
//   c_i      : carry into bit 0
//   sum_o    : slice sum
//   c_o      : carry out of the slice MSB
//   c_msb_o  : carry into the slice MSB (used for signed overflow)
module adder_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] sum_o,
  output logic         c_o,
  output logic         c_msb_o
);

  logic [W:0] c;

  assign c[0] = c_i;

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (c[i]),
      .s_o (sum_o[i]),
      .c_o (c[i+1])
    );
  end

  assign c_o     = c[W];
  assign c_msb_o = c[W-1];

endmodule

// File: rtl/full_adder.sv
// full_adder -- one-bit full adder cell.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder -- STAGES-deep carry-pipelined adder/subtractor.
//   clk, rst      : clock, synchronous active-high reset
//   a_in, b_in    : operands (WIDTH bits)
//   c_in          : carry-in (add) / borrow-in (subtract)
//   sub_in        : 0 = a+b+c_in, 1 = a-b-c_in
//   valid_in      : operands valid       ready_out : operands accepted
//   sum_out       : registered result    carry_out : raw MSB carry
//   overflow_out  : signed overflow      valid_out : result valid
//   ready_in      : downstream accepts result
//
// Handshake: an operand transfer happens on a rising edge where
// valid_in && ready_out; a result transfer happens where valid_out && ready_in.
// The whole pipeline advances together when the output register is empty or
// being drained (enable = !valid_out || ready_in); ready_out is that enable.
// When enable is low every register, valid bits included, holds.
//
// Stage k adds slice k of the operands with the registered carry from stage
// k-1. Operand bits not yet consumed travel forward in a_q/b_q (skew), and
// already-resolved low sum slices travel forward in s_q (deskew). Slices not
// yet computed stay zero in s_q, so each stage simply ORs in its new slice.
// WIDTH must be an integer multiple of STAGES.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             carry_out,
  output logic             overflow_out,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam int SW = slice_width(WIDTH, STAGES);

  // Pipeline registers
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] carry_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              ovf_q;

  // Next-state values
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] carry_d;
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_d;

  // Per-stage slice adder signals
  logic [SW-1:0]     sl_a   [STAGES];
  logic [SW-1:0]     sl_b   [STAGES];
  logic [SW-1:0]     sl_sum [STAGES];
  logic              sl_cmsb [STAGES];
  logic [STAGES-1:0] sl_cin;

  logic             en;
  logic [WIDTH-1:0] b_eff;

  assign en        = !valid_q[STAGES-1] || ready_in;
  assign ready_out = en;

  // Subtraction is a + ~b + ~borrow; stage 0 carry-in is c_in ^ sub_in.
  assign b_eff = sub_in ? ~b_in : b_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign a_d[k]     = a_in;
      assign b_d[k]     = b_eff;
      assign valid_d[k] = valid_in;
      assign sl_cin[k]  = c_in ^ sub_in;
      assign s_d[k]     = WIDTH'(sl_sum[k]);
    end else begin : g_next
      assign a_d[k]     = a_q[k-1];
      assign b_d[k]     = b_q[k-1];
      assign valid_d[k] = valid_q[k-1];
      assign sl_cin[k]  = carry_q[k-1];
      assign s_d[k]     = s_q[k-1] | (WIDTH'(sl_sum[k]) << (k * SW));
    end

    assign sl_a[k] = a_d[k][k*SW +: SW];
    assign sl_b[k] = b_d[k][k*SW +: SW];

    adder_slice #(.W(SW)) u_slice (
      .a_i     (sl_a[k]),
      .b_i     (sl_b[k]),
      .c_i     (sl_cin[k]),
      .sum_o   (sl_sum[k]),
      .c_o     (carry_d[k]),
      .c_msb_o (sl_cmsb[k])
    );
  end

  // Signed overflow: carry into the word MSB differs from carry out of it.
  assign ovf_d = carry_d[STAGES-1] ^ sl_cmsb[STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (en) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign valid_out    = valid_q[STAGES-1];
  assign sum_out      = s_q[STAGES-1];
  assign carry_out    = carry_q[STAGES-1];
  assign overflow_out = ovf_q;

endmodule
